// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode constants
// and the instruction classifier the sequencer uses in EXEC.
package mips_pkg;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_JAL,
        CL_ALU,
        CL_NOP
    } iclass_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;

    // Anything not recognised here retires as a NOP rather than trapping.
    function automatic iclass_e classify(input logic [5:0] op, input logic [5:0] fn);
        iclass_e cl;
        cl = CL_NOP;
        if (op == OP_LW)                                  cl = CL_LOAD;
        else if (op == OP_SW)                             cl = CL_STORE;
        else if (op[5:2] == 4'b0001 || op == OP_REGIMM)   cl = CL_BRANCH;
        else if (op == OP_J || (op == OP_RTYPE && fn == FN_JR)) cl = CL_JUMP;
        else if (op == OP_JAL)                            cl = CL_JAL;
        else if (op == OP_RTYPE || op[5:3] == 3'b001)     cl = CL_ALU;
        return cl;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Saturating wait counter for memory accesses; at_limit is registered-count compare, no latency.
// No backpressure: clr has priority over en, and the count holds once it reaches LIMIT.
module mem_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LIM) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A limit of zero disables trapping entirely.
    assign at_limit = (LIMIT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control over one shared memory port, 3-5 cycles per instruction.
// Memory backpressure via mem_ready stalls FETCH/MEM; a stalled access past TIMEOUT_CYCLES traps to ERROR.
module multicycle_sequencer
    import mips_pkg::*;
#(
    parameter int OPCODE_LENGTH  = 6,
    parameter int FUNCT_LENGTH   = 6,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [OPCODE_LENGTH-1:0] opcode,
    input  logic [FUNCT_LENGTH-1:0]  func,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     iord,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic                     reg_write_en,
    output logic                     retire,
    output logic                     mem_timeout,
    output logic [2:0]               state
);

    state_e  state_q, state_d;
    logic    is_store_q, is_store_d;
    logic    wd_limit;
    iclass_e cls;

    assign cls = classify(opcode, func);

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        retire        = 1'b0;
        case (state_q)
            BOOT:   state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wd_limit) begin
                    state_d = ERROR;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                // Access type is captured here so MEM does not depend on the IR staying put.
                is_store_d = (cls == CL_STORE);
                case (cls)
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_BRANCH: begin
                        pc_write_cond = 1'b1;
                        retire        = 1'b1;
                        state_d       = FETCH;
                    end
                    CL_JUMP: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    CL_JAL: begin
                        pc_write = 1'b1;
                        state_d  = WB;
                    end
                    CL_ALU:  state_d = WB;
                    default: begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    retire  = is_store_q;
                    state_d = is_store_q ? FETCH : WB;
                end else if (wd_limit) begin
                    state_d = ERROR;
                end
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            ERROR:   state_d = ERROR;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= BOOT;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr      (state_d != state_q),
        .en       ((state_q == FETCH || state_q == MEM) && !mem_ready),
        .at_limit (wd_limit)
    );

    assign mem_req      = (state_q == FETCH) || (state_q == MEM);
    assign iord         = (state_q == MEM);
    assign mem_we       = (state_q == MEM) && is_store_q;
    assign reg_write_en = (state_q == WB);
    assign mem_timeout  = (state_q == ERROR);
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle output vector and mem_ready schedule.
module tb_multicycle_sequencer;

    localparam int TO = 15;

    localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_ERROR = 3'd6;

    localparam logic [8:0] REQ = 9'h100, WE = 9'h080, IORD = 9'h040, IRW = 9'h020, PCW = 9'h010,
                           PCC = 9'h008, RWE = 9'h004, RET = 9'h002, TOUT = 9'h001;

    localparam int K_LOAD = 0, K_STORE = 1, K_BR = 2, K_JMP = 3, K_JAL = 4, K_ALU = 5, K_NOP = 6;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [5:0] opcode, func;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic       reg_write_en, retire, mem_timeout;
    logic [2:0] state;

    logic [5:0] cur_op, cur_fn;
    int n_checks = 0, n_fail = 0;
    int exp_retires = 0, got_retires = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .OPCODE_LENGTH (6),
        .FUNCT_LENGTH  (6),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .opcode       (opcode),
        .func         (func),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .reg_write_en (reg_write_en),
        .retire       (retire),
        .mem_timeout  (mem_timeout),
        .state        (state)
    );

    function automatic logic [11:0] obs();
        return {state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                reg_write_en, retire, mem_timeout};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then compare the settled outputs.
    task automatic step(input string tag, input logic rdy, input logic [2:0] st, input logic [8:0] strb);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = cur_op;
        func      = cur_fn;
        #2;
        check_eq(tag, {20'd0, obs()}, {20'd0, st, strb});
        if (retire) got_retires++;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        check_eq("reset_async", {20'd0, obs()}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", {20'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_b     = 1'b1;
        mem_ready = 1'($urandom);
        #2;
        check_eq("boot", {20'd0, obs()}, {20'd0, S_BOOT, 9'd0});
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23:                           return K_LOAD;
            6'h2B:                           return K_STORE;
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return K_BR;
            6'h02:                           return K_JMP;
            6'h03:                           return K_JAL;
            6'h00:                           return (fn == 6'h08) ? K_JMP : K_ALU;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_ALU;
            default:                         return K_NOP;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        int k;
        logic [8:0] ex, w;
        k = kind_of(op, fn);
        cur_op = op;
        cur_fn = fn;
        for (int i = 0; i < wf; i++) step("fetch_wait", 1'b0, S_FETCH, REQ);
        step("fetch", 1'b1, S_FETCH, REQ | IRW | PCW);
        step("decode", 1'($urandom), S_DECODE, 9'd0);
        case (k)
            K_BR:    ex = PCC | RET;
            K_JMP:   ex = PCW | RET;
            K_JAL:   ex = PCW;
            K_NOP:   ex = RET;
            default: ex = 9'd0;
        endcase
        step("exec", 1'($urandom), S_EXEC, ex);
        if (k == K_LOAD || k == K_STORE) begin
            w = (k == K_STORE) ? WE : 9'd0;
            for (int i = 0; i < wm; i++) step("mem_wait", 1'b0, S_MEM, REQ | IORD | w);
            step("mem", 1'b1, S_MEM, REQ | IORD | w | ((k == K_STORE) ? RET : 9'd0));
        end
        if (k == K_LOAD || k == K_ALU || k == K_JAL)
            step("wb", 1'($urandom), S_WB, RWE | RET);
        exp_retires++;
    endtask

    task automatic expect_error();
        for (int i = 0; i < 4; i++) step("error", 1'($urandom), S_ERROR, TOUT);
    endtask

    initial begin
        logic [5:0] tbl_op [16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07,
                                    6'h01, 6'h02, 6'h03, 6'h08, 6'h0F, 6'h3F, 6'h20, 6'h10};
        logic [5:0] tbl_fn [16] = '{6'h20, 6'h22, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        rst_b     = 1'b1;
        mem_ready = 1'b0;
        cur_op    = 6'h00;
        cur_fn    = 6'h00;
        opcode    = 6'h00;
        func      = 6'h00;
        #3;
        do_reset();

        run_instr(6'h00, 6'h20, 0, 0);      // ADD
        run_instr(6'h23, 6'h00, 0, 3);      // LW, 3 wait states
        run_instr(6'h2B, 6'h00, 1, 0);      // SW
        run_instr(6'h04, 6'h00, 0, 0);      // BEQ
        run_instr(6'h02, 6'h00, 0, 0);      // J
        run_instr(6'h3F, 6'h00, 0, 0);      // unknown opcode
        run_instr(6'h00, 6'h20, TO, 0);     // ready on the last allowed cycle

        // FETCH never completes: 16 request cycles, then a sticky trap.
        cur_op = 6'h00;
        for (int i = 0; i < TO + 1; i++) step("to_fetch", 1'b0, S_FETCH, REQ);
        expect_error();
        do_reset();

        // Stalled LW data access traps as well.
        cur_op = 6'h23;
        step("fetch", 1'b1, S_FETCH, REQ | IRW | PCW);
        step("decode", 1'b0, S_DECODE, 9'd0);
        step("exec", 1'b0, S_EXEC, 9'd0);
        for (int i = 0; i < TO + 1; i++) step("to_mem", 1'b0, S_MEM, REQ | IORD);
        expect_error();
        do_reset();

        // Reset arriving mid-MEM aborts the load without writeback or retire.
        step("fetch", 1'b1, S_FETCH, REQ | IRW | PCW);
        step("decode", 1'b0, S_DECODE, 9'd0);
        step("exec", 1'b0, S_EXEC, 9'd0);
        step("mem_wait", 1'b0, S_MEM, REQ | IORD);
        #1;
        mem_ready = 1'b1;
        do_reset();
        run_instr(6'h00, 6'h25, 0, 0);

        for (int n = 0; n < 160; n++) begin
            int idx, wf, wm;
            logic [5:0] op, fn;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                op = tbl_op[idx];
                fn = tbl_fn[idx];
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            wf = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            run_instr(op, fn, wf, wm);
        end

        check_eq("retire_count", got_retires, exp_retires);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
